ic_ram_lane: RTL and testbench
==============================

Name: ic_ram_lane

Overview:
Next-generation instruction-cache data store: a parametrised simple-dual-port distributed RAM (one write port, one read port) for the AWG cache line array. It adds per-lane write enables, a hardware clear engine, a selectable registered read and a selectable same-address bypass. The clear engine replaces power-up array initialisation, which the FPGA flow cannot implement. The block sits under the cache controller, which must hold off fills and lookups while busy=1.

Parameters:
DW, 128, data word width in bits; must be divisible by LANES
AW, 9, address width; depth DP = 2^AW
LANES, 4, number of independently writable lanes; lane width LW = DW/LANES
OUT_REG, 1, 1 = registered read (1-cycle latency); 0 = asynchronous read (0 latency)
BYPASS, 1, 1 = write-first on same-address collision; 0 = read-first (old data)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
clr_req  in  1  single-cycle request to zero the whole array
busy  out  1  clear in progress; user writes are blocked
wea  in  1  write strobe
lane_en  in  LANES  per-lane write enable; lane i covers dina[i*LW +: LW]
addra  in  AW  write address
dina  in  DW  write data
wr_drop  out  1  one-cycle pulse: wea arrived while busy=1 and was discarded
rd_en  in  1  read strobe
addrb  in  AW  read address
doutb  out  DW  read data
doutb_vld  out  1  doutb is valid for a read issued per the latency rule

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: busy=1, wr_drop=0, doutb=0 (registered path), doutb_vld=0, FSM=CLEAR, clear counter=0. Array contents are not reset directly; the clear engine zeroes them.
- FSM states:
  - CLEAR: writes 0 to ram[cnt]; cnt increments by 1 each cycle. At cnt==DP-1 the FSM moves to IDLE. busy=1 for exactly DP cycles after rst is released.
  - IDLE: busy=0. clr_req=1 moves to CLEAR with cnt=0 on the next edge.
  - clr_req while in CLEAR is ignored and does not restart the count.
  - rst asserted mid-clear restarts the clear from address 0.
- User write (IDLE only): for each i with wea & lane_en[i], ram[addra][i*LW +: LW] <= dina lane i. Lanes with lane_en[i]=0 are unchanged. wea with lane_en all 0 is a no-op.
- Write while busy: the write is discarded and wr_drop pulses high on the following cycle.
- Read, OUT_REG=1:
  - rd_en at cycle N gives doutb and doutb_vld=1 at N+1.
  - doutb holds its value when rd_en=0. doutb_vld=0 on cycles with no read.
- Read, OUT_REG=0:
  - doutb = array[addrb] combinationally; doutb_vld = rd_en & ~busy.
- Read while busy: doutb_vld stays 0; data is don't-care.
- Collision (rd_en & wea, addrb==addra, IDLE):
  - BYPASS=1: returned data = lanes with lane_en[i] set taken from dina, other lanes from the array.
  - BYPASS=0: returned data = array contents before the write.
- Address wrap: the clear counter is AW bits with terminal detect at DP-1; there is no overflow wrap into user space.
- Elaboration check: DW % LANES != 0 is a fatal elaboration error.

Decomposition:
- Shared package/include ic_ram_pkg: FSM state encodings (IDLE=1'b0, CLEAR=1'b1), derived constants DP and LW, and the lane-merge function (old word, new word, lane mask -> merged word). The cache controller reuses the same merge function.
- One sub-module, ic_ram_clr_fsm: contains the state register, clear counter, busy and wr_drop generation.
- Array write mux, bypass and output register live in ic_ram_lane.

Test Plan:
- Release rst, defaults -> busy=1 for 512 cycles and 0 at cycle 513; reading addrb=0..511 afterwards returns 0 with doutb_vld one cycle after each rd_en.
- wea, lane_en=4'b0101, addra=0x05, dina=all 0xA5, then read 0x05 -> lanes 0 and 2 = 0xA5A5A5A5, lanes 1 and 3 = 0.
- Same-cycle wea and rd_en to 0x10 after the array is cleared, dina=all 0xFF, lane_en=4'b1111 -> BYPASS=1 returns all 0xFF; BYPASS=0 returns 0.
- clr_req at cycle 20 of IDLE after writes -> busy for 512 cycles. A wea during busy gives a wr_drop pulse and no array change. A second clr_req at clear count 100 does not extend busy.
- rst asserted at clear count 300 -> clear restarts; busy stays high for 512 cycles after release.
- OUT_REG=0 build: write 0x1234 to addr 7 (lane_en all 1), then set addrb=7, rd_en=1 -> doutb=0x1234 and doutb_vld=1 in the same cycle.

Source files
------------

// File: rtl/ic_ram_pkg.sv
// Shared definitions for the instruction-cache data store: clear-FSM states,
// default geometry and the lane-merge helper also used by the cache controller.
package ic_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int DW_DEF    = 128;
    localparam int AW_DEF    = 9;
    localparam int LANES_DEF = 4;
    localparam int DP        = 2 ** AW_DEF;
    localparam int LW        = DW_DEF / LANES_DEF;

    // The merge helper works on the widest supported word so one function
    // serves every parametrisation; callers zero-extend and truncate.
    localparam int MAX_DW    = 1024;
    localparam int MAX_LANES = 64;

    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0]    old_word,
        input logic [MAX_DW-1:0]    new_word,
        input logic [MAX_LANES-1:0] lane_mask,
        input int                   lane_w
    );
        logic [MAX_DW-1:0] merged;
        int                lane;
        merged = old_word;
        for (int b = 0; b < MAX_DW; b++) begin
            lane = b / lane_w;
            if (lane < MAX_LANES) begin
                if (lane_mask[6'(lane)]) begin
                    merged[b] = new_word[b];
                end
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ic_ram_lane_if.sv
// Controller-facing bus of the cache data store: fill port, lookup port and
// clear handshake.
interface ic_ram_lane_if #(
    parameter int DW    = 128,
    parameter int AW    = 9,
    parameter int LANES = 4
) ();
    logic             clr_req;
    logic             busy;
    logic             wea;
    logic [LANES-1:0] lane_en;
    logic [AW-1:0]    addra;
    logic [DW-1:0]    dina;
    logic             wr_drop;
    logic             rd_en;
    logic [AW-1:0]    addrb;
    logic [DW-1:0]    doutb;
    logic             doutb_vld;

    modport master (
        output clr_req, wea, lane_en, addra, dina, rd_en, addrb,
        input  busy, wr_drop, doutb, doutb_vld
    );

    modport slave (
        input  clr_req, wea, lane_en, addra, dina, rd_en, addrb,
        output busy, wr_drop, doutb, doutb_vld
    );
endinterface

// File: rtl/ic_ram_clr_fsm.sv
// Clear engine: walks every address once after reset or on request, holding
// busy high meanwhile and flagging writes that arrive while busy.
module ic_ram_clr_fsm
    import ic_ram_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr_req,
    input  logic          i_wea,
    output logic          o_busy,
    output logic          o_wr_drop,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);
    localparam logic [AW-1:0] CNT_LAST = '1;

    clr_state_t    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_wr_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= i_wea & r_busy;
            case (r_state)
                ST_CLEAR: begin
                    // Requests during a clear are ignored; the count never restarts.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ST_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_wr_drop  = r_wr_drop;
    assign o_clr_we   = (r_state == ST_CLEAR);
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ic_ram_lane.sv
// Instruction-cache line data store: lane-writable distributed RAM with a
// clear engine, optional output register and optional write-first bypass.
module ic_ram_lane
    import ic_ram_pkg::*;
#(
    parameter int DW      = 128,
    parameter int AW      = 9,
    parameter int LANES   = 4,
    parameter int OUT_REG = 1,
    parameter int BYPASS  = 1
) (
    input  logic         clk,
    input  logic         rst,
    ic_ram_lane_if.slave bus
);
    localparam int DEPTH  = 2 ** AW;
    localparam int LANE_W = DW / LANES;

    if (DW % LANES != 0) begin : g_bad_lanes
        $fatal(1, "ic_ram_lane: DW must be divisible by LANES");
    end
    if (DW > MAX_DW || LANES > MAX_LANES) begin : g_too_wide
        $fatal(1, "ic_ram_lane: DW or LANES exceeds lane_merge limits");
    end

    logic          w_busy;
    logic          w_wr_drop;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_user_we;
    logic          w_rd_ok;
    logic          w_collision;
    logic [DW-1:0] w_rd_word;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_rd_data;

    ic_ram_clr_fsm #(.AW(AW)) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (bus.clr_req),
        .i_wea      (bus.wea),
        .o_busy     (w_busy),
        .o_wr_drop  (w_wr_drop),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_user_we = bus.wea & ~w_busy;
    assign w_rd_ok   = bus.rd_en & ~w_busy;

    // One array per lane so each lane write enable maps onto its own RAM slice.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] r_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end else if (w_user_we && bus.lane_en[gi]) begin
                r_mem[bus.addra] <= bus.dina[gi*LANE_W +: LANE_W];
            end
        end

        assign w_rd_word[gi*LANE_W +: LANE_W] = r_mem[bus.addrb];
    end

    assign w_collision = bus.rd_en & w_user_we & (bus.addrb == bus.addra);
    assign w_merged    = DW'(lane_merge(MAX_DW'(w_rd_word), MAX_DW'(bus.dina),
                                        MAX_LANES'(bus.lane_en), LANE_W));
    assign w_rd_data   = (BYPASS != 0 && w_collision) ? w_merged : w_rd_word;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] r_doutb;
        logic          r_doutb_vld;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_doutb     <= '0;
                r_doutb_vld <= 1'b0;
            end else begin
                r_doutb_vld <= w_rd_ok;
                if (w_rd_ok) begin
                    r_doutb <= w_rd_data;
                end
            end
        end

        assign bus.doutb     = r_doutb;
        assign bus.doutb_vld = r_doutb_vld;
    end else begin : g_out_comb
        assign bus.doutb     = w_rd_data;
        assign bus.doutb_vld = w_rd_ok;
    end

    assign bus.busy    = w_busy;
    assign bus.wr_drop = w_wr_drop;

endmodule

// File: tb/tb_ic_ram_lane.sv
// Directed plus randomized checks of the cache data store against a word-level
// reference model (registered/bypass build and asynchronous/read-first build).
module tb_ic_ram_lane;
    localparam int DW    = 128;
    localparam int AW    = 9;
    localparam int LANES = 4;
    localparam int LW    = DW / LANES;
    localparam int DP    = 2 ** AW;
    localparam int AW2   = 4;
    localparam int DP2   = 2 ** AW2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ic_ram_lane_if #(.DW(DW), .AW(AW),  .LANES(LANES)) bus ();
    ic_ram_lane_if #(.DW(DW), .AW(AW2), .LANES(LANES)) bus2 ();

    ic_ram_lane #(.DW(DW), .AW(AW), .LANES(LANES), .OUT_REG(1), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ic_ram_lane #(.DW(DW), .AW(AW2), .LANES(LANES), .OUT_REG(0), .BYPASS(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Reference model: array contents, cycles of busy remaining, expected outputs.
    logic [DW-1:0] mem_m  [DP];
    logic [DW-1:0] mem2_m [DP2];
    int            left_m;
    int            left2_m;
    logic          drop_m;
    logic          vld_m;
    logic [DW-1:0] dout_m;
    logic          was_rst;

    int checks   = 0;
    int failures = 0;

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                              input logic [LANES-1:0] en);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (en[i]) r[i*LW +: LW] = new_w[i*LW +: LW];
        end
        return r;
    endfunction

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic tick();
        logic busy_pre;
        logic busy2_pre;
        @(posedge clk);
        busy_pre  = (left_m > 0);
        busy2_pre = (left2_m > 0);
        was_rst   = rst;
        if (rst) begin
            left_m = DP; drop_m = 1'b0; vld_m = 1'b0; dout_m = '0;
            for (int a = 0; a < DP; a++) mem_m[a] = '0;
            left2_m = DP2;
            for (int a = 0; a < DP2; a++) mem2_m[a] = '0;
        end else begin
            drop_m = bus.wea & busy_pre;
            vld_m  = bus.rd_en & ~busy_pre;
            if (vld_m) begin
                if (bus.wea && bus.addra == bus.addrb)
                    dout_m = merge_m(mem_m[bus.addrb], bus.dina, bus.lane_en);
                else
                    dout_m = mem_m[bus.addrb];
            end
            if (bus.wea && !busy_pre)
                mem_m[bus.addra] = merge_m(mem_m[bus.addra], bus.dina, bus.lane_en);
            if (busy_pre) left_m--;
            else if (bus.clr_req) begin
                left_m = DP;
                for (int a = 0; a < DP; a++) mem_m[a] = '0;
            end
            if (busy2_pre) left2_m--;
            else begin
                if (bus2.wea)
                    mem2_m[bus2.addra] = merge_m(mem2_m[bus2.addra], bus2.dina, bus2.lane_en);
                if (bus2.clr_req) begin
                    left2_m = DP2;
                    for (int a = 0; a < DP2; a++) mem2_m[a] = '0;
                end
            end
        end
        #1;
        chk_b("busy", bus.busy, left_m > 0);
        chk_b("wr_drop", bus.wr_drop, drop_m);
        chk_b("doutb_vld", bus.doutb_vld, vld_m);
        if (vld_m || was_rst) chk_w("doutb", bus.doutb, dout_m);
    endtask

    // Combinational outputs of the asynchronous build for the current inputs.
    task automatic chk2(input string tag);
        #1;
        chk_b({tag, "_busy"}, bus2.busy, left2_m > 0);
        chk_b({tag, "_vld"}, bus2.doutb_vld, bus2.rd_en & (left2_m == 0));
        if (bus2.rd_en && left2_m == 0) chk_w({tag, "_dout"}, bus2.doutb, mem2_m[bus2.addrb]);
    endtask

    // Counts cycles until busy drops; mode 1 injects a dropped write and a
    // repeated clear request part-way through.
    task automatic run_clear(input int exp_n, input string tag, input int mode);
        int n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (mode == 1 && n == 5) begin
                bus.wea = 1'b1; bus.lane_en = 4'hF; bus.addra = 9'h003;
                bus.dina = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mode == 1 && n == 100) bus.clr_req = 1'b1;
            tick();
            if (mode == 1 && n == 5) begin
                chk_b("wr_drop_pulse", bus.wr_drop, 1'b1);
                bus.wea = 1'b0;
            end
            if (mode == 1 && n == 100) bus.clr_req = 1'b0;
            n++;
        end
        chk_i(tag, n, exp_n);
        $display("clear %s: busy for %0d cycles", tag, n);
    endtask

    initial begin
        rst = 1'b1;
        bus.clr_req = 0; bus.wea = 0; bus.lane_en = '0; bus.addra = '0; bus.dina = '0;
        bus.rd_en = 0; bus.addrb = '0;
        bus2.clr_req = 0; bus2.wea = 0; bus2.lane_en = '0; bus2.addra = '0; bus2.dina = '0;
        bus2.rd_en = 0; bus2.addrb = '0;
        left_m = 0; left2_m = 0; drop_m = 0; vld_m = 0; dout_m = '0; was_rst = 0;

        repeat (3) tick();
        chk_b("reset_busy", bus.busy, 1'b1);
        chk_w("reset_doutb", bus.doutb, '0);
        rst = 1'b0;
        run_clear(DP, "init_busy", 0);

        // Every address reads zero after the initial clear.
        for (int i = 0; i < DP; i++) begin
            bus.rd_en = 1'b1; bus.addrb = AW'(i);
            tick();
        end
        bus.rd_en = 1'b0;
        tick();
        $display("sweep: read %0d addresses after initial clear", DP);

        // Partial lane write.
        bus.wea = 1'b1; bus.lane_en = 4'b0101; bus.addra = 9'h005; bus.dina = {16{8'hA5}};
        tick();
        bus.wea = 1'b0; bus.rd_en = 1'b1; bus.addrb = 9'h005;
        tick();
        chk_w("lane_write", bus.doutb, {32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5});
        $display("txn lane write addr=005 dout=%h", bus.doutb);

        // Same-address collision, write-first.
        bus.wea = 1'b1; bus.lane_en = 4'hF; bus.addra = 9'h010; bus.dina = '1;
        bus.rd_en = 1'b1; bus.addrb = 9'h010;
        tick();
        chk_w("bypass", bus.doutb, {DW{1'b1}});
        $display("txn bypass addr=010 dout=%h", bus.doutb);
        bus.wea = 1'b0; bus.rd_en = 1'b0;

        // Random traffic over a small address window to provoke collisions.
        for (int t = 0; t < 300; t++) begin
            bus.wea = 1'($urandom_range(0, 1)); bus.lane_en = 4'($urandom);
            bus.addra = AW'($urandom_range(0, 15));
            bus.dina = {$urandom, $urandom, $urandom, $urandom};
            bus.rd_en = 1'($urandom_range(0, 1)); bus.addrb = AW'($urandom_range(0, 15));
            tick();
            $display("txn %0d wea=%b lane=%b wa=%h rd=%b ra=%h vld=%b dout=%h", t, bus.wea,
                     bus.lane_en, bus.addra, bus.rd_en, bus.addrb, bus.doutb_vld, bus.doutb);
        end
        bus.wea = 1'b0; bus.rd_en = 1'b0;

        // Clear request 20 cycles into idle, with a dropped write and a repeated request.
        repeat (20) tick();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        run_clear(DP, "clr_busy", 1);
        bus.rd_en = 1'b1; bus.addrb = 9'h003;
        tick();
        chk_w("drop_no_write", bus.doutb, '0);
        bus.rd_en = 1'b1; bus.addrb = 9'h005;
        tick();
        chk_w("cleared_005", bus.doutb, '0);
        bus.rd_en = 1'b0;

        // Reset part-way through a clear restarts it.
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (300) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        run_clear(DP, "rst_restart", 0);

        // Asynchronous, read-first build.
        bus2.wea = 1'b1; bus2.lane_en = 4'hF; bus2.addra = 4'h7; bus2.dina = 128'h1234;
        chk2("async_wr");
        tick();
        bus2.wea = 1'b0; bus2.rd_en = 1'b1; bus2.addrb = 4'h7;
        chk2("async_rd");
        chk_w("async_read", bus2.doutb, 128'h1234);
        chk_b("async_vld", bus2.doutb_vld, 1'b1);
        $display("txn async read addr=7 dout=%h vld=%b", bus2.doutb, bus2.doutb_vld);
        bus2.wea = 1'b1; bus2.dina = '1; bus2.addra = 4'h7;
        chk2("rf_col");
        chk_w("read_first", bus2.doutb, 128'h1234);
        tick();
        bus2.wea = 1'b0;
        chk2("rf_after");
        chk_w("read_after", bus2.doutb, {DW{1'b1}});
        for (int t = 0; t < 40; t++) begin
            bus2.wea = 1'($urandom_range(0, 1)); bus2.lane_en = 4'($urandom);
            bus2.addra = AW2'($urandom); bus2.dina = {$urandom, $urandom, $urandom, $urandom};
            bus2.rd_en = 1'($urandom_range(0, 1)); bus2.addrb = AW2'($urandom);
            chk2("async_rand");
            $display("txn2 %0d wea=%b lane=%b wa=%h rd=%b ra=%h dout=%h", t, bus2.wea,
                     bus2.lane_en, bus2.addra, bus2.rd_en, bus2.addrb, bus2.doutb);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
